prog_mem: RTL and testbench
===========================

Name: prog_mem

Overview:
- Parametrised, writable program memory that replaces the fixed instruction table on the mother board.
- CPU side has the same combinational read as before: an address in, an instruction word out.
- A second port lets a host or loader stream a new program in at runtime through a valid/ready byte handshake.
- While loading, the block asserts cpu_hold so the CPU core freezes its PC.

Parameters:
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W words.
- DATA_W, 8, instruction word width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- addr  input  ADDR_W  CPU fetch address.
- data  output  DATA_W  instruction at addr (combinational from array).
- load_start  input  1  request to begin a full-program load.
- load_abort  input  1  abandon an in-progress load.
- load_valid  input  1  load_data holds a valid word.
- load_data  input  DATA_W  word to write at the current write pointer.
- load_ready  output  1  block accepts a word this cycle.
- load_count  output  ADDR_W+1  number of words written in the current/last load.
- load_done  output  1  one-cycle pulse after the final word is written.
- cpu_hold  output  1  high while in LOAD or DONE; the CPU must not advance.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset effects:
  - All DEPTH words cleared to 0 (encodes ADD A,0, i.e. a NOP).
  - FSM goes to IDLE; wptr=0; load_count=0.
  - load_ready=0, load_done=0, cpu_hold=0.
- Read port: data = mem[addr] combinationally, in every state, including during a load.
- Write visibility: a word written at edge N is visible on data from edge N onward (zero cycles after the write edge).
- FSM states: IDLE, LOAD, DONE.
  - IDLE:
    - load_ready=0, cpu_hold=0.
    - load_start=1 -> LOAD next; wptr<=0; load_count<=0.
    - load_valid is ignored.
  - LOAD:
    - load_ready=1, cpu_hold=1.
    - Transfer occurs when load_valid & load_ready: mem[wptr]<=load_data; wptr<=wptr+1; load_count<=load_count+1.
    - Transfer with wptr==DEPTH-1 -> DONE next; load_count becomes DEPTH; wptr wraps to 0.
    - load_abort=1 -> IDLE next, with no write that cycle even if load_valid=1 (abort wins). Words already written are kept; the rest are unchanged. load_count holds the words written.
    - load_start is ignored.
    - load_valid=0 stalls with no state change, for any length of time.
  - DONE:
    - load_done=1 for exactly this one cycle; cpu_hold=1; load_ready=0.
    - Unconditionally -> IDLE next.
    - load_start and load_abort are ignored.
- load_count width ADDR_W+1 so that DEPTH is representable. It is held until the next load_start or rst.
- rst asserted mid-load: clears memory and returns to IDLE next edge; load_done is not pulsed.
- load_start and load_abort both high in IDLE: start wins (abort only meaningful in LOAD).
- No X on any output after the first reset edge.

Test Plan:
- Reset, then sweep addr 0..15 -> data=8'h00 at every address; cpu_hold=0, load_ready=0, load_count=0.
- Pulse load_start, then stream 16 words back-to-back (0x60,0x90,0x3D,0x01,0xE3,0x51,0xE1,0xB0,0xBF,0xF7,0x00 x6) ->
  - load_ready=1 and cpu_hold=1 for 16 cycles;
  - load_done pulses one cycle after the 16th transfer;
  - load_count=16;
  - addr 3 reads 8'h01, addr 9 reads 8'hF7.
- Repeat the load with load_valid toggled every other cycle -> exactly 16 writes; same final contents; load_done only once; cpu_hold high throughout.
- Start a load, write 5 words (0xAA..0xAE), then assert load_abort together with load_valid=1 and data 0xFF ->
  - IDLE next cycle; load_count=5;
  - addr 0..4 read 0xAA..0xAE; addr 5 reads its prior value (not 0xFF);
  - no load_done.
- Mid-load (after 8 words), assert rst -> all addresses read 0x00; FSM IDLE; load_count=0; no load_done pulse.
- In LOAD, assert load_start again and in DONE assert load_abort -> both ignored; load completes normally; returns to IDLE one cycle after DONE.

Source files
------------

// File: rtl/prog_mem.sv
// prog_mem -- writable program memory with a runtime byte-stream loader.
//
// The CPU reads instructions combinationally (data = mem[addr]) at all times.
// A host streams a complete program in through a valid/ready handshake; while
// the load is in progress, and for the one DONE cycle after it, cpu_hold
// freezes the CPU's program counter.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   synchronous active-high reset (clears memory as well)
//   addr        in   CPU fetch address
//   data        out  instruction at addr (combinational)
//   load_start  in   begin a full-program load (acted on in IDLE only)
//   load_abort  in   abandon a load in progress (acted on in LOAD only)
//   load_valid  in   load_data is valid
//   load_data   in   word written at the current write pointer
//   load_ready  out  a word is accepted this cycle (LOAD)
//   load_count  out  words written by the current or last load
//   load_done   out  one-cycle pulse in the cycle after the final write
//   cpu_hold    out  high in LOAD and DONE
module prog_mem #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    input  logic              load_start,
    input  logic              load_abort,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    output logic [ADDR_W:0]   load_count,
    output logic              load_done,
    output logic              cpu_hold
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:0]   r_wptr;
    logic [ADDR_W:0]     r_count;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic                w_xfer;
    logic                w_last;
    logic                w_start;

    // Abort takes priority over a concurrent valid word: nothing is written.
    assign w_xfer  = (r_state == S_LOAD) && load_valid && !load_abort;
    assign w_last  = (r_wptr == ADDR_W'(DEPTH - 1));
    assign w_start = (r_state == S_IDLE) && load_start;

    // ---------------- State register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- Next-state logic ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (load_start) begin
                    w_state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                if (load_abort) begin
                    w_state_next = S_IDLE;
                end else if (w_xfer && w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ---------------- Output logic ----------------
    always_comb begin
        load_ready = 1'b0;
        load_done  = 1'b0;
        cpu_hold   = 1'b0;
        case (r_state)
            S_LOAD: begin
                load_ready = 1'b1;
                cpu_hold   = 1'b1;
            end
            S_DONE: begin
                load_done = 1'b1;
                cpu_hold  = 1'b1;
            end
            default: begin
                load_ready = 1'b0;
            end
        endcase
    end

    // ---------------- Write pointer and word counter ----------------
    // The pointer wraps naturally to 0 after the final word; the counter is
    // one bit wider so it can hold DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_count <= '0;
        end else if (w_start) begin
            r_wptr  <= '0;
            r_count <= '0;
        end else if (w_xfer) begin
            r_wptr  <= r_wptr + 1'b1;
            r_count <= r_count + 1'b1;
        end
    end

    assign load_count = r_count;

    // ---------------- Storage ----------------
    // Every word must clear on reset, so the array is built from individual
    // registers rather than a RAM primitive.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_mem[gi] <= '0;
                end else if (w_xfer && (r_wptr == ADDR_W'(gi))) begin
                    r_mem[gi] <= load_data;
                end
            end
        end
    endgenerate

    assign data = r_mem[addr];

endmodule

// File: tb/tb_prog_mem.sv
module tb_prog_mem;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] addr;
    logic [7:0] data;
    logic       load_start;
    logic       load_abort;
    logic       load_valid;
    logic [7:0] load_data;
    logic       load_ready;
    logic [4:0] load_count;
    logic       load_done;
    logic       cpu_hold;

    int errors = 0;
    int checks = 0;

    logic [7:0] prog [16];
    logic [7:0] abort_words [5];

    prog_mem #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .addr       (addr),
        .data       (data),
        .load_start (load_start),
        .load_abort (load_abort),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .load_count (load_count),
        .load_done  (load_done),
        .cpu_hold   (cpu_hold)
    );

    always #5 clk = ~clk;

    // Advance one rising edge; inputs change and outputs are sampled 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_status(input string tag, input logic ready, input logic hold,
                              input logic done);
        chk({tag, "_ready"}, 32'(load_ready), 32'(ready));
        chk({tag, "_hold"},  32'(cpu_hold),   32'(hold));
        chk({tag, "_done"},  32'(load_done),  32'(done));
    endtask

    task automatic chk_all_zero(input string tag);
        for (int a = 0; a < 16; a++) begin
            addr = 4'(a);
            #1;
            chk($sformatf("%s_mem%0d", tag, a), 32'(data), 32'h0);
        end
    endtask

    task automatic chk_prog(input string tag);
        for (int a = 0; a < 16; a++) begin
            addr = 4'(a);
            #1;
            chk($sformatf("%s_mem%0d", tag, a), 32'(data), 32'(prog[a]));
        end
    endtask

    initial begin
        int n;
        int cyc;
        int done_seen;

        prog[0]  = 8'h60; prog[1]  = 8'h90; prog[2]  = 8'h3D; prog[3]  = 8'h01;
        prog[4]  = 8'hE3; prog[5]  = 8'h51; prog[6]  = 8'hE1; prog[7]  = 8'hB0;
        prog[8]  = 8'hBF; prog[9]  = 8'hF7;
        for (int i = 10; i < 16; i++) prog[i] = 8'h00;
        for (int i = 0; i < 5; i++) abort_words[i] = 8'hAA + 8'(i);

        rst = 1'b1; addr = '0; load_start = 0; load_abort = 0; load_valid = 0; load_data = '0;

        // ---- Reset state ----
        step(); step();
        rst = 1'b0;
        chk_all_zero("reset");
        chk_status("reset", 1'b0, 1'b0, 1'b0);
        chk("reset_count", 32'(load_count), 32'd0);
        $display("T reset: memory clear, idle");

        // ---- IDLE ignores load_valid ----
        load_valid = 1; load_data = 8'h5A;
        step();
        load_valid = 0;
        chk_status("idle_valid", 1'b0, 1'b0, 1'b0);
        addr = 0; #1;
        chk("idle_valid_mem0", 32'(data), 32'h0);
        chk("idle_valid_count", 32'(load_count), 32'd0);
        $display("T idle: load_valid ignored");

        // ---- Back-to-back full load ----
        load_start = 1;
        step();
        load_start = 0;
        for (int i = 0; i < 16; i++) begin
            load_valid = 1; load_data = prog[i]; addr = 4'(i);
            #1;
            chk_status($sformatf("b2b_w%0d", i), 1'b1, 1'b1, 1'b0);
            step();
            // written word visible right after its write edge
            chk($sformatf("b2b_vis%0d", i), 32'(data), 32'(prog[i]));
        end
        load_valid = 0;
        chk_status("b2b_done", 1'b0, 1'b1, 1'b1);
        chk("b2b_count", 32'(load_count), 32'd16);
        step();
        chk_status("b2b_idle", 1'b0, 1'b0, 1'b0);
        addr = 3; #1; chk("b2b_addr3", 32'(data), 32'h01);
        addr = 9; #1; chk("b2b_addr9", 32'(data), 32'hF7);
        chk_prog("b2b");
        $display("T load back-to-back: 16 words, count=%0d", load_count);

        // ---- Load with valid toggling (memory cleared first) ----
        rst = 1; step(); rst = 0;
        chk_all_zero("tog_pre");
        load_start = 1;
        step();
        load_start = 0;
        n = 0; cyc = 0; done_seen = 0;
        while (n < 16 && cyc < 100) begin
            load_valid = (cyc % 2 == 0);
            load_data  = load_valid ? prog[n] : 8'hEE;
            #1;
            chk_status($sformatf("tog_c%0d", cyc), 1'b1, 1'b1, 1'b0);
            step();
            if (load_valid) n++;
            cyc++;
        end
        chk("tog_bound", 32'(n), 32'd16);
        load_valid = 0;
        chk_status("tog_done", 1'b0, 1'b1, 1'b1);
        chk("tog_count", 32'(load_count), 32'd16);
        for (int k = 0; k < 3; k++) begin
            step();
            if (load_done) done_seen++;
        end
        chk("tog_done_once", 32'(done_seen), 32'd0);
        chk_status("tog_idle", 1'b0, 1'b0, 1'b0);
        chk_prog("tog");
        $display("T load toggled valid: %0d cycles, count=%0d", cyc, load_count);

        // ---- Abort after 5 words, abort wins over concurrent valid ----
        load_start = 1;
        step();
        load_start = 0;
        for (int i = 0; i < 5; i++) begin
            load_valid = 1; load_data = abort_words[i];
            step();
        end
        load_valid = 1; load_data = 8'hFF; load_abort = 1;
        step();
        load_valid = 0; load_abort = 0;
        chk_status("abort_idle", 1'b0, 1'b0, 1'b0);
        chk("abort_count", 32'(load_count), 32'd5);
        for (int a = 0; a < 5; a++) begin
            addr = 4'(a); #1;
            chk($sformatf("abort_mem%0d", a), 32'(data), 32'(abort_words[a]));
        end
        addr = 5; #1;
        chk("abort_mem5", 32'(data), 32'h51);
        step();
        chk_status("abort_after", 1'b0, 1'b0, 1'b0);
        chk("abort_count_held", 32'(load_count), 32'd5);
        $display("T abort: count=%0d mem5=%0h", load_count, data);

        // ---- Reset mid-load after 8 words ----
        load_start = 1;
        step();
        load_start = 0;
        for (int i = 0; i < 8; i++) begin
            load_valid = 1; load_data = prog[i];
            step();
        end
        rst = 1; load_valid = 1; load_data = 8'h77;
        step();
        rst = 0; load_valid = 0;
        chk_status("rst_mid", 1'b0, 1'b0, 1'b0);
        chk("rst_mid_count", 32'(load_count), 32'd0);
        chk_all_zero("rst_mid");
        step();
        chk_status("rst_mid_after", 1'b0, 1'b0, 1'b0);
        $display("T reset mid-load: memory cleared, idle");

        // ---- Start and abort together in IDLE: start wins ----
        load_start = 1; load_abort = 1;
        step();
        load_start = 0; load_abort = 0;
        chk_status("start_abort_idle", 1'b1, 1'b1, 1'b0);
        chk("start_abort_count", 32'(load_count), 32'd0);
        load_abort = 1;
        step();
        load_abort = 0;
        chk_status("start_abort_exit", 1'b0, 1'b0, 1'b0);
        $display("T start+abort in idle: start wins");

        // ---- load_start in LOAD and load_abort in DONE ignored ----
        load_start = 1;
        step();
        for (int i = 0; i < 16; i++) begin
            load_start = 1; load_valid = 1; load_data = prog[i];
            step();
            if (i == 7) chk("restart_mid_count", 32'(load_count), 32'd8);
        end
        load_start = 0; load_valid = 0; load_abort = 1;
        chk_status("ignore_done", 1'b0, 1'b1, 1'b1);
        chk("ignore_count", 32'(load_count), 32'd16);
        step();
        load_abort = 0;
        chk_status("ignore_idle", 1'b0, 1'b0, 1'b0);
        chk("ignore_count_held", 32'(load_count), 32'd16);
        step();
        chk_status("ignore_idle2", 1'b0, 1'b0, 1'b0);
        chk_prog("ignore");
        $display("T start in LOAD / abort in DONE ignored: count=%0d", load_count);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
